// File: rtl/spi_master_ctrl_if.sv
// Signal bundle between spi_master_ctrl, the processor-side registers, the TX/RX
// shift registers and the SPI pins. "master" is the sequencer side.
interface spi_master_ctrl_if;
   logic       start_i;
   logic [7:0] tx_data_i;
   logic [7:0] rx_byte_i;
   logic [7:0] tx_byte_o;
   logic       tx_load_o;
   logic       tx_shift_o;
   logic       rx_shift_o;
   logic       sclk_o;
   logic       cs_n_o;
   logic       busy_o;
   logic       done_o;
   logic [7:0] rx_data_o;

   modport master (
      input  start_i, tx_data_i, rx_byte_i,
      output tx_byte_o, tx_load_o, tx_shift_o, rx_shift_o,
             sclk_o, cs_n_o, busy_o, done_o, rx_data_o
   );

   modport slave (
      output start_i, tx_data_i, rx_byte_i,
      input  tx_byte_o, tx_load_o, tx_shift_o, rx_shift_o,
             sclk_o, cs_n_o, busy_o, done_o, rx_data_o
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-3 SPI byte sequencer driving external TX/RX shift registers with load/shift strobes.
// Define SPI_BURST_EN to chain back-to-back bytes under one chip-select without SETUP/HOLD.
module spi_master_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input logic               clk_i,
   input logic               rst_i,
   spi_master_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} state_e;

   localparam int DIV_W   = $clog2(CLK_DIV + 1);
   localparam int FRM_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int FRM_W   = $clog2(FRM_MAX + 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [FRM_W-1:0] SETUP_LAST = FRM_W'(CS_SETUP - 1);
   localparam logic [FRM_W-1:0] HOLD_LAST  = FRM_W'(CS_HOLD - 1);
   localparam logic [3:0]       BITS       = 4'd8;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [FRM_W-1:0] frm_q, frm_d;
   logic [3:0]       bit_q, bit_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             tx_load_q, tx_load_d;
   logic             tx_shift_q, tx_shift_d;
   logic             rx_shift_q, rx_shift_d;
   logic             sclk_q, sclk_d;
   logic             cs_n_q, cs_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      div_d      = div_q;
      frm_d      = frm_q;
      bit_d      = bit_q;
      tx_byte_d  = tx_byte_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      tx_load_d  = 1'b0;
      tx_shift_d = 1'b0;
      rx_shift_d = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d   = SETUP;
               tx_byte_d = bus.tx_data_i;
               tx_load_d = 1'b1;
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               frm_d     = '0;
               bit_d     = '0;
            end
         end
         SETUP: begin
            if (frm_q == SETUP_LAST) begin
               state_d = LOW;
               sclk_d  = 1'b0;
               div_d   = '0;
            end else begin
               frm_d = frm_q + 1'b1;
            end
         end
         LOW: begin
            if (div_q == DIV_LAST) begin
               state_d    = HIGH;
               sclk_d     = 1'b1;
               rx_shift_d = 1'b1;
               bit_d      = bit_q + 4'd1;
               div_d      = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         HIGH: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 1'b1;
            end else if (bit_q != BITS) begin
               // The first falling edge comes from SETUP, so only edges 2..8 shift.
               state_d    = LOW;
               sclk_d     = 1'b0;
               tx_shift_d = 1'b1;
               div_d      = '0;
            end else begin
`ifdef SPI_BURST_EN
               if (bus.start_i) begin
                  state_d   = LOW;
                  sclk_d    = 1'b0;
                  tx_byte_d = bus.tx_data_i;
                  tx_load_d = 1'b1;
                  done_d    = 1'b1;
                  rx_data_d = bus.rx_byte_i;
                  bit_d     = '0;
                  div_d     = '0;
               end else begin
                  state_d = HOLD;
                  frm_d   = '0;
               end
`else
               state_d = HOLD;
               frm_d   = '0;
`endif
            end
         end
         HOLD: begin
            if (frm_q == HOLD_LAST) begin
               state_d   = IDLE;
               cs_n_d    = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = bus.rx_byte_i;
            end else begin
               frm_d = frm_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         div_q      <= '0;
         frm_q      <= '0;
         bit_q      <= '0;
         tx_byte_q  <= '0;
         rx_data_q  <= '0;
         tx_load_q  <= 1'b0;
         tx_shift_q <= 1'b0;
         rx_shift_q <= 1'b0;
         sclk_q     <= 1'b1;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         frm_q      <= frm_d;
         bit_q      <= bit_d;
         tx_byte_q  <= tx_byte_d;
         rx_data_q  <= rx_data_d;
         tx_load_q  <= tx_load_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.tx_byte_o  = tx_byte_q;
   assign bus.tx_load_o  = tx_load_q;
   assign bus.tx_shift_o = tx_shift_q;
   assign bus.rx_shift_o = rx_shift_q;
   assign bus.sclk_o     = sclk_q;
   assign bus.cs_n_o     = cs_n_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.rx_data_o  = rx_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (default, CLK_DIV=1) with behavioural TX/RX
// shift registers and MISO looped to MOSI; expected bytes and done cycles go through a scoreboard.
module tb_spi_master_ctrl;
   localparam int LAT0    = 1 + 2 + 16 * 4 + 2;
   localparam int LAT1    = 1 + 2 + 16 * 1 + 2;
   localparam int BURST_L = 1 + 2 + 16 * 4;

   typedef struct { logic [7:0] data; int due; } exp_t;
   typedef struct { logic [7:0] data; int cyc; } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   exp_t sb0[$];
   exp_t sb1[$];
   obs_t ob0[$];
   obs_t ob1[$];

   int   n_rxs = 0, n_txs = 0, n_load = 0, n_rise = 0, n_done = 0;
   int   cs_rise_cyc = 0, cs_high_len = 0;
   logic sclk_prev = 1'b1, cs_prev = 1'b1;
   logic [7:0] tx_sr0 = '0, rx_sr0 = '0, tx_sr1 = '0, rx_sr1 = '0;

   spi_master_ctrl_if b0();
   spi_master_ctrl_if b1();

   spi_master_ctrl dut0 (.clk_i(clk), .rst_i(rst), .bus(b0.master));
   spi_master_ctrl #(.CLK_DIV(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign b0.rx_byte_i = rx_sr0;
   assign b1.rx_byte_i = rx_sr1;

   always @(posedge clk) begin
      if (b0.tx_load_o) tx_sr0 <= b0.tx_byte_o;
      else if (b0.tx_shift_o) tx_sr0 <= {tx_sr0[6:0], 1'b0};
      if (b0.rx_shift_o) rx_sr0 <= {rx_sr0[6:0], tx_sr0[7]};
      if (b1.tx_load_o) tx_sr1 <= b1.tx_byte_o;
      else if (b1.tx_shift_o) tx_sr1 <= {tx_sr1[6:0], 1'b0};
      if (b1.rx_shift_o) rx_sr1 <= {rx_sr1[6:0], tx_sr1[7]};
   end

   always @(negedge clk) begin
      if (b0.rx_shift_o) n_rxs++;
      if (b0.tx_shift_o) n_txs++;
      if (b0.tx_load_o) n_load++;
      if (b0.sclk_o && !sclk_prev) n_rise++;
      if (b0.cs_n_o && !cs_prev) cs_rise_cyc = cyc;
      if (!b0.cs_n_o && cs_prev) cs_high_len = cyc - cs_rise_cyc;
      if (b0.done_o) begin
         n_done++;
         ob0.push_back('{b0.rx_data_o, cyc});
      end
      if (b1.done_o) ob1.push_back('{b1.rx_data_o, cyc});
      sclk_prev = b0.sclk_o;
      cs_prev   = b0.cs_n_o;
   end

   task automatic send(input bit which, input logic [7:0] d, output int acc);
      @(posedge clk); #1;
      acc = cyc;
      if (which) begin
         b1.start_i = 1'b1; b1.tx_data_i = d;
         sb1.push_back('{d, acc + LAT1});
      end else begin
         b0.start_i = 1'b1; b0.tx_data_i = d;
         sb0.push_back('{d, acc + LAT0});
      end
      @(posedge clk); #1;
      b0.start_i = 1'b0;
      b1.start_i = 1'b0;
   endtask

   task automatic drain(input bit which, input int budget);
      exp_t e;
      obs_t o;
      int   waited;
      while ((which ? sb1.size() : sb0.size()) > 0) begin
         waited = 0;
         while ((which ? ob1.size() : ob0.size()) == 0 && waited < budget) begin
            @(negedge clk);
            waited++;
         end
         total++;
         if ((which ? ob1.size() : ob0.size()) == 0) begin
            bad++;
            $display("FAIL done_timeout dut%0d: no done_o in %0d cycles, %0d bytes outstanding",
                     which, budget, which ? sb1.size() : sb0.size());
            if (which) sb1.delete(); else sb0.delete();
            return;
         end
         if (which) begin e = sb1.pop_front(); o = ob1.pop_front(); end
         else begin e = sb0.pop_front(); o = ob0.pop_front(); end
         if (o.data !== e.data) begin
            bad++;
            $display("FAIL rx_data dut%0d: got %02h want %02h", which, o.data, e.data);
         end
         total++;
         if (o.cyc != e.due) begin
            bad++;
            $display("FAIL done_cycle dut%0d: got %0d want %0d", which, o.cyc, e.due);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({b0.sclk_o, b0.cs_n_o, b0.busy_o, b0.done_o, b0.tx_load_o, b0.tx_shift_o, b0.rx_shift_o} !== 7'b1100000) begin
         bad++;
         $display("FAIL reset_ctrl dut0: got %b want 1100000",
                  {b0.sclk_o, b0.cs_n_o, b0.busy_o, b0.done_o, b0.tx_load_o, b0.tx_shift_o, b0.rx_shift_o});
      end
      total++;
      if (b0.tx_byte_o !== 8'h00 || b0.rx_data_o !== 8'h00) begin
         bad++;
         $display("FAIL reset_data dut0: tx_byte=%02h rx_data=%02h want 00/00", b0.tx_byte_o, b0.rx_data_o);
      end
      total++;
      if ({b1.sclk_o, b1.cs_n_o, b1.busy_o, b1.done_o} !== 4'b1100) begin
         bad++;
         $display("FAIL reset_ctrl dut1: got %b want 1100", {b1.sclk_o, b1.cs_n_o, b1.busy_o, b1.done_o});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] pats [5];
      int acc, s_rxs, s_txs, s_load, s_rise;
      pats = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h69};
      foreach (pats[i]) begin
         s_rxs = n_rxs; s_txs = n_txs; s_load = n_load; s_rise = n_rise;
         send(1'b0, pats[i], acc);
         @(negedge clk);
         total++;
         if ({b0.cs_n_o, b0.busy_o, b0.tx_load_o} !== 3'b011) begin
            bad++;
            $display("FAIL first_cycle %02h: cs_n/busy/load=%b want 011", pats[i],
                     {b0.cs_n_o, b0.busy_o, b0.tx_load_o});
         end
         total++;
         if (b0.tx_byte_o !== pats[i]) begin
            bad++;
            $display("FAIL tx_byte: got %02h want %02h", b0.tx_byte_o, pats[i]);
         end
         drain(1'b0, 200);
         total++;
         if (n_rxs - s_rxs != 8 || n_txs - s_txs != 7 || n_load - s_load != 1 || n_rise - s_rise != 8) begin
            bad++;
            $display("FAIL strobes %02h: rx_shift=%0d tx_shift=%0d load=%0d rise=%0d want 8/7/1/8", pats[i],
                     n_rxs - s_rxs, n_txs - s_txs, n_load - s_load, n_rise - s_rise);
         end
      end
   endtask

   task automatic test_clkdiv1();
      int   acc;
      int   mism = 0;
      logic want;
      send(1'b1, 8'h81, acc);
      for (int c = 1; c < LAT1; c++) begin
         @(negedge clk);
         want = (c >= 3 && c <= 18) ? (((c - 3) % 2) == 1) : 1'b1;
         if (b1.sclk_o !== want) mism++;
      end
      total++;
      if (mism != 0) begin
         bad++;
         $display("FAIL sclk_div1: %0d cycles wrong, want 0", mism);
      end
      drain(1'b1, 60);
   endtask

   task automatic test_ignore();
      int acc;
      int s_done = n_done;
      send(1'b0, 8'h96, acc);
      repeat (20) @(posedge clk);
      #1;
      b0.start_i = 1'b1; b0.tx_data_i = 8'hFF;
      @(posedge clk); #1;
      b0.start_i = 1'b0;
      @(negedge clk);
      total++;
      if (b0.tx_byte_o !== 8'h96 || b0.busy_o !== 1'b1) begin
         bad++;
         $display("FAIL ignore_start: tx_byte=%02h busy=%b want 96/1", b0.tx_byte_o, b0.busy_o);
      end
      drain(1'b0, 200);
      repeat (80) @(negedge clk);
      total++;
      if (n_done - s_done != 1 || ob0.size() != 0) begin
         bad++;
         $display("FAIL ignore_done_count: got %0d done pulses want 1", n_done - s_done);
      end
   endtask

`ifndef SPI_BURST_EN
   task automatic test_back_to_back();
      int acc;
      int s_done = n_done;
      @(posedge clk); #1;
      acc = cyc;
      b0.start_i = 1'b1; b0.tx_data_i = 8'h4D;
      sb0.push_back('{8'h4D, acc + LAT0});
      sb0.push_back('{8'hB2, acc + 2 * LAT0});
      @(posedge clk); #1;
      b0.tx_data_i = 8'hB2;
      repeat (LAT0) @(posedge clk);
      #1;
      b0.start_i = 1'b0;
      drain(1'b0, 300);
      total++;
      if (cs_high_len != 1) begin
         bad++;
         $display("FAIL cs_gap: got %0d cycles high want 1", cs_high_len);
      end
      total++;
      if (n_done - s_done != 2) begin
         bad++;
         $display("FAIL b2b_done_count: got %0d want 2", n_done - s_done);
      end
   endtask
`else
   task automatic test_burst();
      int acc, high_cnt;
      int s_rxs = n_rxs, s_txs = n_txs, s_load = n_load, s_rise = n_rise;
      high_cnt = 0;
      @(posedge clk); #1;
      acc = cyc;
      b0.start_i = 1'b1; b0.tx_data_i = 8'h3C;
      sb0.push_back('{8'h3C, acc + BURST_L});
      sb0.push_back('{8'hC3, acc + BURST_L + 16 * 4 + 2});
      for (int c = 1; c <= BURST_L + 16 * 4 + 1; c++) begin
         @(negedge clk);
         if (c == 1) b0.tx_data_i = 8'hC3;
         if (b0.cs_n_o) high_cnt++;
         if (c == BURST_L) b0.start_i = 1'b0;
      end
      drain(1'b0, 200);
      total++;
      if (high_cnt != 0) begin
         bad++;
         $display("FAIL burst_cs: cs_n high %0d cycles want 0", high_cnt);
      end
      total++;
      if (n_rise - s_rise != 16 || n_rxs - s_rxs != 16 || n_txs - s_txs != 14 || n_load - s_load != 2) begin
         bad++;
         $display("FAIL burst_strobes: rise=%0d rx=%0d tx=%0d load=%0d want 16/16/14/2",
                  n_rise - s_rise, n_rxs - s_rxs, n_txs - s_txs, n_load - s_load);
      end
   endtask
`endif

   task automatic test_reset_mid();
      int acc, waited;
      int s_done = n_done;
      int s_rise = n_rise;
      send(1'b0, 8'h5A, acc);
      waited = 0;
      while (n_rise - s_rise < 4 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (n_rise - s_rise < 4) begin
         bad++;
         $display("FAIL rise_timeout: saw %0d rising edges want 4", n_rise - s_rise);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb0.delete();
      @(negedge clk);
      total++;
      if ({b0.cs_n_o, b0.sclk_o, b0.busy_o, b0.done_o} !== 4'b1100 || b0.rx_data_o !== 8'h00) begin
         bad++;
         $display("FAIL mid_reset: cs_n/sclk/busy/done=%b rx_data=%02h want 1100/00",
                  {b0.cs_n_o, b0.sclk_o, b0.busy_o, b0.done_o}, b0.rx_data_o);
      end
      repeat (150) @(negedge clk);
      total++;
      if (n_done != s_done) begin
         bad++;
         $display("FAIL mid_reset_done: got %0d done pulses want 0", n_done - s_done);
      end
   endtask

   initial begin
      b0.start_i = 1'b0; b0.tx_data_i = '0;
      b1.start_i = 1'b0; b1.tx_data_i = '0;
      test_reset();
      test_basic();
      test_clkdiv1();
      test_ignore();
`ifndef SPI_BURST_EN
      test_back_to_back();
`else
      test_burst();
`endif
      test_reset_mid();
      total++;
      if (ob0.size() != 0 || ob1.size() != 0) begin
         bad++;
         $display("FAIL spurious_done: %0d/%0d unexpected done pulses", ob0.size(), ob1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
